csb_master_arb: RTL and testbench
=================================

CSB_MASTER_ARB -- requirements
Module: csb_master_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters sharing one CSB master (legal 2..8).
REQ-002 SHALL have parameter TIMEOUT, default 1023, response-wait cycles before timeout flag (legal 1..65535).
REQ-003 clk  input  1  clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-requester request pending; held until req_ack.
REQ-006 req_pd  input  63*NUM_REQ  per-requester CSB packet, slice i = [63*i+62:63*i], same field layout as mseq2mcsb_pd.
REQ-007 req_ack  output  NUM_REQ  one-cycle pulse: request i consumed by master.
REQ-008 rsp_valid  output  NUM_REQ  one-cycle pulse: response for requester i.
REQ-009 rsp_data  output  32  read data; valid with rsp_valid, else 0.
REQ-010 mseq_pending_req  output  1  request pending toward CSB master.
REQ-011 mseq2mcsb_pd  output  63  granted packet toward CSB master.
REQ-012 mcsb2mseq_consumed_req  input  1  master accepted the packet.
REQ-013 mcsb2mseq_rvalid  input  1  master transaction complete.
REQ-014 mcsb2mseq_rdata  input  32  master read data.
REQ-015 busy  output  1  transaction in flight (state != IDLE).
REQ-016 timeout_err  output  1  sticky: a response wait reached TIMEOUT cycles.

Function
REQ-017 SHALL allow exactly one outstanding master transaction at a time.
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT_RSP.
REQ-019 IDLE: if any req_valid, SHALL pick grant by round-robin starting at last_grant+1 (mod NUM_REQ), latch grant_id, update last_grant, go ISSUE next cycle; else stay.
REQ-020 ISSUE: mseq2mcsb_pd SHALL equal req_pd slice of grant_id; mseq_pending_req SHALL be (state==ISSUE) AND NOT mcsb2mseq_consumed_req (combinational, prevents master re-issue on posted write).
REQ-021 ISSUE + consumed_req: req_ack[grant_id] pulses same cycle; if mcsb2mseq_rvalid also high (posted write) -> rsp_valid[grant_id] pulses same cycle, go IDLE; else go WAIT_RSP.
REQ-022 WAIT_RSP: on mcsb2mseq_rvalid -> rsp_valid[grant_id]=1, rsp_data=mcsb2mseq_rdata same cycle, go IDLE.
REQ-023 Wait counter (16 bit) SHALL clear on entry to ISSUE, increment each WAIT_RSP cycle, saturate; reaching TIMEOUT SHALL set timeout_err; FSM keeps waiting.
REQ-024 rvalid outside ISSUE/WAIT_RSP SHALL be ignored (no rsp_valid).
REQ-025 Requester dropping req_valid while granted in ISSUE: transaction still issued with current pd; requester is responsible for stability.
REQ-026 Minimum turnaround: IDLE cycle between consecutive grants; back-to-back throughput 1 txn per (3 + master latency) cycles.
REQ-027 Non-granted requests SHALL remain pending without ack; no requester starved beyond NUM_REQ-1 grants.
REQ-028 All outputs except mseq_pending_req, req_ack, rsp_valid, rsp_data SHALL be registered; those four are combinational from state and master inputs.

Reset
REQ-029 On reset low: state=IDLE, last_grant=NUM_REQ-1 (requester 0 first), grant_id=0, counter=0, timeout_err=0; all outputs 0 immediately.
REQ-030 Reset mid-transaction SHALL abandon it without ack/rsp; master is reset by same reset.

Verification
REQ-031 Single read: req_valid=01, pd write=0 addr=0x1000; master rvalid with rdata=0xCAFE0001 -> req_ack[0] one pulse, rsp_valid[0] pulse, rsp_data=0xCAFE0001, back to IDLE.
REQ-032 Posted write: consumed_req and rvalid same cycle -> req_ack[0] and rsp_valid[0] same cycle, mseq_pending_req=0 that cycle, IDLE next.
REQ-033 Contention: req_valid=11 continuously, 4 transactions -> grant order 0,1,0,1.
REQ-034 Timeout: read issued, rvalid withheld 1023 cycles -> timeout_err=1 at count 1023, stays 1 after later rvalid until reset.
REQ-035 Reset asserted in WAIT_RSP -> busy=0, no rsp_valid, next grant goes to requester 0.

Source files
------------

// File: rtl/csb_master_arb.sv
// Round-robin arbiter letting several requesters share one CSB master port,
// with a single outstanding transaction and a sticky response-timeout flag.
//
// state    | meaning
// ---------|-----------------------------------------------------------
// IDLE     | no transaction; pick next requester round-robin
// ISSUE    | granted packet presented to master, waiting for consumed_req
// WAIT_RSP | packet accepted, waiting for master rvalid
module csb_master_arb #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     i_req_valid,
  input  logic [63*NUM_REQ-1:0]  i_req_pd,
  output logic [NUM_REQ-1:0]     o_req_ack,
  output logic [NUM_REQ-1:0]     o_rsp_valid,
  output logic [31:0]            o_rsp_data,
  output logic                   o_mseq_pending_req,
  output logic [62:0]            o_mseq2mcsb_pd,
  input  logic                   i_mcsb2mseq_consumed_req,
  input  logic                   i_mcsb2mseq_rvalid,
  input  logic [31:0]            i_mcsb2mseq_rdata,
  output logic                   o_busy,
  output logic                   o_timeout_err
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] TO_CNT = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE    = 2'd1,
    S_WAIT_RSP = 2'd2
  } state_t;

  state_t          r_state;
  logic [GW-1:0]   r_last_grant;
  logic [GW-1:0]   r_grant_id;
  logic [15:0]     r_wait_cnt;
  logic            r_timeout_err;
  logic [62:0]     r_pd;

  logic [GW-1:0]       w_pick;
  logic                w_pick_vld;
  logic [62:0]         w_pick_pd;
  logic [15:0]         w_cnt_inc;
  logic [NUM_REQ-1:0]  w_grant_oh;
  logic                w_issue;
  logic                w_wait;
  logic                w_ack;
  logic                w_rsp;

  // Scan downward so the last match written is the one closest after last_grant.
  always_comb begin
    w_pick     = r_last_grant;
    w_pick_vld = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(r_last_grant) + k) % NUM_REQ;
      if (i_req_valid[idx]) begin
        w_pick     = GW'(idx);
        w_pick_vld = 1'b1;
      end
    end
  end

  assign w_pick_pd  = i_req_pd[63*int'(w_pick) +: 63];
  assign w_cnt_inc  = (r_wait_cnt == 16'hFFFF) ? r_wait_cnt : r_wait_cnt + 16'd1;
  assign w_grant_oh = NUM_REQ'(1) << r_grant_id;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_last_grant  <= GW'(NUM_REQ - 1);
      r_grant_id    <= '0;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
      r_pd          <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pick_vld) begin
            r_grant_id   <= w_pick;
            r_last_grant <= w_pick;
            r_pd         <= w_pick_pd;
            r_wait_cnt   <= '0;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (i_mcsb2mseq_consumed_req) begin
            r_state <= i_mcsb2mseq_rvalid ? S_IDLE : S_WAIT_RSP;
          end
        end
        S_WAIT_RSP: begin
          r_wait_cnt <= w_cnt_inc;
          // The FSM keeps waiting after a timeout; the flag is only a report.
          if (w_cnt_inc >= TO_CNT) begin
            r_timeout_err <= 1'b1;
          end
          if (i_mcsb2mseq_rvalid) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_issue = (r_state == S_ISSUE);
  assign w_wait  = (r_state == S_WAIT_RSP);
  assign w_ack   = w_issue & i_mcsb2mseq_consumed_req;
  assign w_rsp   = (w_ack & i_mcsb2mseq_rvalid) | (w_wait & i_mcsb2mseq_rvalid);

  // Dropped in the consume cycle so a posted write is not seen twice by the master.
  assign o_mseq_pending_req = w_issue & ~i_mcsb2mseq_consumed_req;
  assign o_req_ack          = w_ack ? w_grant_oh : '0;
  assign o_rsp_valid        = w_rsp ? w_grant_oh : '0;
  assign o_rsp_data         = w_rsp ? i_mcsb2mseq_rdata : 32'd0;
  assign o_mseq2mcsb_pd     = r_pd;
  assign o_busy             = (r_state != S_IDLE);
  assign o_timeout_err      = r_timeout_err;

endmodule

// File: tb/tb_csb_master_arb.sv
// Bench for csb_master_arb: scenario tasks with a round-robin reference model,
// randomized packets, latencies and request masks.
module tb_csb_master_arb;
  localparam int N  = 3;
  localparam int TO = 1023;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [N-1:0]      i_req_valid = '0;
  logic [63*N-1:0]   i_req_pd = '0;
  logic [N-1:0]      o_req_ack;
  logic [N-1:0]      o_rsp_valid;
  logic [31:0]       o_rsp_data;
  logic              o_mseq_pending_req;
  logic [62:0]       o_mseq2mcsb_pd;
  logic              i_mcsb2mseq_consumed_req = 1'b0;
  logic              i_mcsb2mseq_rvalid = 1'b0;
  logic [31:0]       i_mcsb2mseq_rdata = '0;
  logic              o_busy;
  logic              o_timeout_err;

  int errors = 0;
  int checks = 0;
  int model_last = N - 1;
  bit model_to = 1'b0;
  logic [62:0] pd_arr [N];

  csb_master_arb #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .i_req_valid              (i_req_valid),
    .i_req_pd                 (i_req_pd),
    .o_req_ack                (o_req_ack),
    .o_rsp_valid              (o_rsp_valid),
    .o_rsp_data               (o_rsp_data),
    .o_mseq_pending_req       (o_mseq_pending_req),
    .o_mseq2mcsb_pd           (o_mseq2mcsb_pd),
    .i_mcsb2mseq_consumed_req (i_mcsb2mseq_consumed_req),
    .i_mcsb2mseq_rvalid       (i_mcsb2mseq_rvalid),
    .i_mcsb2mseq_rdata        (i_mcsb2mseq_rdata),
    .o_busy                   (o_busy),
    .o_timeout_err            (o_timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic int rr_pick(input int last, input logic [N-1:0] mask);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  function automatic int oh2id(input logic [N-1:0] v);
    int id;
    id = -1;
    if ($countones(v) > 1) return -2;
    for (int i = 0; i < N; i++) if (v[i]) id = i;
    return id;
  endfunction

  function automatic logic [62:0] rand_pd();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[62:0];
  endfunction

  task automatic drive_pd();
    for (int i = 0; i < N; i++) i_req_pd[63*i +: 63] = pd_arr[i];
  endtask

  // One transaction starting in an IDLE cycle: stall = ISSUE cycles before consume,
  // lat = WAIT_RSP cycles (0 means posted write).
  task automatic run_txn(input logic [N-1:0] mask, input int stall, input int lat,
                         input logic [31:0] rdata,
                         output int ack_id, output int rsp_id, output logic [31:0] rsp_d,
                         output int n_ack, output int n_rsp, output logic [62:0] pd_seen,
                         output bit pend_ok, output bit same_cyc, output bit idle_ok,
                         output bit quiet_ok);
    @(negedge clk);
    i_req_valid = mask;
    drive_pd();
    i_mcsb2mseq_consumed_req = 1'b0;
    i_mcsb2mseq_rvalid = 1'b0;
    i_mcsb2mseq_rdata = $urandom;
    #1;
    idle_ok = (o_busy == 1'b0) && (o_req_ack == '0) && (o_rsp_valid == '0) &&
              (o_mseq_pending_req == 1'b0);
    @(posedge clk);
    pend_ok = 1'b1; quiet_ok = 1'b1; same_cyc = 1'b0;
    n_ack = 0; n_rsp = 0; ack_id = -1; rsp_id = -1; rsp_d = '0; pd_seen = '0;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      #1;
      if (!o_mseq_pending_req || o_req_ack != '0 || o_rsp_valid != '0 || !o_busy) pend_ok = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    i_mcsb2mseq_consumed_req = 1'b1;
    i_mcsb2mseq_rvalid = (lat == 0);
    i_mcsb2mseq_rdata = rdata;
    #1;
    pd_seen = o_mseq2mcsb_pd;
    if (o_mseq_pending_req) pend_ok = 1'b0;
    n_ack += $countones(o_req_ack);
    ack_id = oh2id(o_req_ack);
    if (o_rsp_valid != '0) begin
      n_rsp += $countones(o_rsp_valid);
      rsp_id = oh2id(o_rsp_valid);
      rsp_d = o_rsp_data;
    end else if (o_rsp_data != '0) quiet_ok = 1'b0;
    same_cyc = (o_req_ack != '0) && (o_rsp_valid != '0);
    @(posedge clk);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      i_mcsb2mseq_consumed_req = 1'b0;
      i_mcsb2mseq_rvalid = (c == lat);
      i_mcsb2mseq_rdata = (c == lat) ? rdata : $urandom;
      #1;
      n_ack += $countones(o_req_ack);
      if (o_mseq_pending_req) pend_ok = 1'b0;
      if (o_rsp_valid != '0) begin
        n_rsp += $countones(o_rsp_valid);
        rsp_id = oh2id(o_rsp_valid);
        rsp_d = o_rsp_data;
      end else if (o_rsp_data != '0) quiet_ok = 1'b0;
      @(posedge clk);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    i_req_valid = '0;
    i_mcsb2mseq_consumed_req = 1'b0;
    i_mcsb2mseq_rvalid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_last = N - 1;
    model_to = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    i_req_valid = '1;
    i_mcsb2mseq_consumed_req = 1'b1;
    i_mcsb2mseq_rvalid = 1'b1;
    i_mcsb2mseq_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({o_busy, o_timeout_err, o_mseq_pending_req} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: busy/timeout/pending=%b required 000",
               {o_busy, o_timeout_err, o_mseq_pending_req});
    end
    checks++;
    if ({o_req_ack, o_rsp_valid, o_rsp_data, o_mseq2mcsb_pd} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ack=%b rsp=%b data=%h pd=%h required all zero",
               o_req_ack, o_rsp_valid, o_rsp_data, o_mseq2mcsb_pd);
    end
    @(negedge clk);
    i_req_valid = '0;
    i_mcsb2mseq_consumed_req = 1'b0;
    i_mcsb2mseq_rvalid = 1'b0;
    reset = 1'b1;
    model_last = N - 1;
  endtask

  task automatic test_single_read();
    int ack_id, rsp_id, n_ack, n_rsp, exp;
    logic [31:0] rsp_d;
    logic [62:0] pd_seen;
    bit pend_ok, same_cyc, idle_ok, quiet_ok;
    pd_arr[0] = 63'h0000_0000_0000_1000;
    pd_arr[1] = rand_pd();
    pd_arr[2] = rand_pd();
    exp = rr_pick(model_last, 3'b001);
    model_last = exp;
    run_txn(3'b001, 1, 2, 32'hCAFE_0001, ack_id, rsp_id, rsp_d, n_ack, n_rsp, pd_seen,
            pend_ok, same_cyc, idle_ok, quiet_ok);
    checks++;
    if (ack_id !== 0 || n_ack !== 1) begin
      errors++;
      $display("FAIL single_ack: id=%0d pulses=%0d required id=0 pulses=1", ack_id, n_ack);
    end
    checks++;
    if (rsp_id !== 0 || n_rsp !== 1 || rsp_d !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL single_rsp: id=%0d pulses=%0d data=%h required 0/1/cafe0001",
               rsp_id, n_rsp, rsp_d);
    end
    checks++;
    if (pd_seen !== pd_arr[0]) begin
      errors++;
      $display("FAIL single_pd: pd=%h required %h", pd_seen, pd_arr[0]);
    end
    checks++;
    if (!pend_ok || !idle_ok || !quiet_ok) begin
      errors++;
      $display("FAIL single_handshake: pend_ok=%0d idle_ok=%0d quiet_ok=%0d required 1/1/1",
               pend_ok, idle_ok, quiet_ok);
    end
    @(negedge clk);
    i_req_valid = '0;
    i_mcsb2mseq_consumed_req = 1'b0;
    i_mcsb2mseq_rvalid = 1'b0;
    #1;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%b required 0", o_busy);
    end
  endtask

  task automatic test_posted_write();
    int ack_id, rsp_id, n_ack, n_rsp, exp;
    logic [31:0] rsp_d;
    logic [62:0] pd_seen;
    bit pend_ok, same_cyc, idle_ok, quiet_ok;
    pd_arr[0] = rand_pd();
    pd_arr[0][54] = 1'b1;
    exp = rr_pick(model_last, 3'b001);
    model_last = exp;
    run_txn(3'b001, 0, 0, 32'h0, ack_id, rsp_id, rsp_d, n_ack, n_rsp, pd_seen,
            pend_ok, same_cyc, idle_ok, quiet_ok);
    checks++;
    if (!same_cyc || ack_id !== 0 || rsp_id !== 0 || n_ack !== 1 || n_rsp !== 1) begin
      errors++;
      $display("FAIL posted_same_cycle: same=%0d ack=%0d rsp=%0d nack=%0d nrsp=%0d required 1/0/0/1/1",
               same_cyc, ack_id, rsp_id, n_ack, n_rsp);
    end
    checks++;
    if (!pend_ok || pd_seen !== pd_arr[0]) begin
      errors++;
      $display("FAIL posted_pending: pend_ok=%0d pd=%h required 1 and pd %h",
               pend_ok, pd_seen, pd_arr[0]);
    end
    @(negedge clk);
    i_req_valid = '0;
    i_mcsb2mseq_consumed_req = 1'b0;
    i_mcsb2mseq_rvalid = 1'b0;
    #1;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL posted_idle: busy=%b required 0", o_busy);
    end
  endtask

  task automatic test_contention();
    int ack_id, rsp_id, n_ack, n_rsp;
    logic [31:0] rsp_d, rd;
    logic [62:0] pd_seen;
    bit pend_ok, same_cyc, idle_ok, quiet_ok;
    int order [4];
    order = '{0, 1, 0, 1};
    pulse_reset();
    for (int i = 0; i < N; i++) pd_arr[i] = rand_pd();
    for (int t = 0; t < 4; t++) begin
      rd = $urandom;
      run_txn(3'b011, $urandom_range(0, 1), $urandom_range(0, 3), rd, ack_id, rsp_id,
              rsp_d, n_ack, n_rsp, pd_seen, pend_ok, same_cyc, idle_ok, quiet_ok);
      model_last = order[t];
      checks++;
      if (ack_id !== order[t] || rsp_id !== order[t] || rsp_d !== rd ||
          pd_seen !== pd_arr[order[t]] || !idle_ok) begin
        errors++;
        $display("FAIL contention_%0d: ack=%0d rsp=%0d data=%h idle_ok=%0d required grant %0d data %h",
                 t, ack_id, rsp_id, rsp_d, idle_ok, order[t], rd);
      end
    end
  endtask

  task automatic test_random();
    int ack_id, rsp_id, n_ack, n_rsp, exp;
    logic [31:0] rsp_d, rd;
    logic [62:0] pd_seen;
    logic [N-1:0] mask;
    bit pend_ok, same_cyc, idle_ok, quiet_ok;
    for (int t = 0; t < 24; t++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) pd_arr[i] = rand_pd();
      rd = $urandom;
      exp = rr_pick(model_last, mask);
      run_txn(mask, $urandom_range(0, 2), $urandom_range(0, 4), rd, ack_id, rsp_id,
              rsp_d, n_ack, n_rsp, pd_seen, pend_ok, same_cyc, idle_ok, quiet_ok);
      model_last = exp;
      checks++;
      if (ack_id !== exp || n_ack !== 1 || rsp_id !== exp || n_rsp !== 1) begin
        errors++;
        $display("FAIL random_grant_%0d: mask=%b ack=%0d/%0d rsp=%0d/%0d required %0d once",
                 t, mask, ack_id, n_ack, rsp_id, n_rsp, exp);
      end
      checks++;
      if (rsp_d !== rd || pd_seen !== pd_arr[exp]) begin
        errors++;
        $display("FAIL random_data_%0d: data=%h pd=%h required %h pd %h",
                 t, rsp_d, pd_seen, rd, pd_arr[exp]);
      end
      checks++;
      if (!pend_ok || !idle_ok || !quiet_ok || o_timeout_err !== model_to) begin
        errors++;
        $display("FAIL random_proto_%0d: pend=%0d idle=%0d quiet=%0d tmo=%b required 1/1/1/%0d",
                 t, pend_ok, idle_ok, quiet_ok, o_timeout_err, model_to);
      end
    end
  endtask

  task automatic test_spurious_rvalid();
    @(negedge clk);
    i_req_valid = '0;
    i_mcsb2mseq_consumed_req = 1'b1;
    i_mcsb2mseq_rvalid = 1'b1;
    i_mcsb2mseq_rdata = 32'h1234_5678;
    #1;
    checks++;
    if (o_rsp_valid !== '0 || o_req_ack !== '0 || o_rsp_data !== 32'd0) begin
      errors++;
      $display("FAIL spurious_rvalid: rsp=%b ack=%b data=%h required 0/0/0",
               o_rsp_valid, o_req_ack, o_rsp_data);
    end
    @(negedge clk);
    i_mcsb2mseq_consumed_req = 1'b0;
    i_mcsb2mseq_rvalid = 1'b0;
    #1;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL spurious_busy: busy=%b required 0", o_busy);
    end
  endtask

  task automatic test_timeout();
    int exp;
    int ack_id, rsp_id, n_ack, n_rsp;
    logic [31:0] rsp_d;
    logic [62:0] pd_seen;
    bit pend_ok, same_cyc, idle_ok, quiet_ok;
    exp = rr_pick(model_last, 3'b100);
    model_last = exp;
    @(negedge clk);
    i_req_valid = 3'b100;
    @(posedge clk);
    @(negedge clk);
    i_mcsb2mseq_consumed_req = 1'b1;
    @(posedge clk);
    for (int c = 1; c < TO; c++) begin
      @(negedge clk);
      i_mcsb2mseq_consumed_req = 1'b0;
      i_mcsb2mseq_rvalid = 1'b0;
      @(posedge clk);
    end
    @(negedge clk);
    #1;
    checks++;
    if (o_timeout_err !== 1'b0 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: tmo=%b busy=%b after %0d waits required 0/1",
               o_timeout_err, o_busy, TO - 1);
    end
    @(posedge clk);
    model_to = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (o_timeout_err !== 1'b1 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_hit: tmo=%b busy=%b after %0d waits required 1/1",
               o_timeout_err, o_busy, TO);
    end
    repeat (4) @(negedge clk);
    i_mcsb2mseq_rvalid = 1'b1;
    i_mcsb2mseq_rdata = 32'hA5A5_0F0F;
    #1;
    checks++;
    if (o_rsp_valid !== 3'b100 || o_rsp_data !== 32'hA5A5_0F0F) begin
      errors++;
      $display("FAIL timeout_late_rsp: rsp=%b data=%h required 100/a5a50f0f",
               o_rsp_valid, o_rsp_data);
    end
    @(negedge clk);
    i_req_valid = '0;
    i_mcsb2mseq_rvalid = 1'b0;
    #1;
    checks++;
    if (o_timeout_err !== 1'b1 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_sticky: tmo=%b busy=%b required 1/0", o_timeout_err, o_busy);
    end
    exp = rr_pick(model_last, 3'b011);
    model_last = exp;
    run_txn(3'b011, 0, 1, 32'h0, ack_id, rsp_id, rsp_d, n_ack, n_rsp, pd_seen,
            pend_ok, same_cyc, idle_ok, quiet_ok);
    checks++;
    if (o_timeout_err !== 1'b1 || ack_id !== exp) begin
      errors++;
      $display("FAIL timeout_after_txn: tmo=%b ack=%0d required 1 and grant %0d",
               o_timeout_err, ack_id, exp);
    end
  endtask

  task automatic test_reset_mid();
    int ack_id, rsp_id, n_ack, n_rsp;
    logic [31:0] rsp_d;
    logic [62:0] pd_seen;
    bit pend_ok, same_cyc, idle_ok, quiet_ok;
    @(negedge clk);
    i_req_valid = 3'b010;
    @(posedge clk);
    @(negedge clk);
    i_mcsb2mseq_consumed_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_mcsb2mseq_consumed_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    i_mcsb2mseq_rvalid = 1'b1;
    i_mcsb2mseq_rdata = 32'h7777_0000;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_rsp_valid !== '0 || o_rsp_data !== 32'd0 ||
        o_timeout_err !== 1'b0 || o_req_ack !== '0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b rsp=%b data=%h tmo=%b ack=%b required all 0",
               o_busy, o_rsp_valid, o_rsp_data, o_timeout_err, o_req_ack);
    end
    @(negedge clk);
    i_req_valid = '0;
    i_mcsb2mseq_rvalid = 1'b0;
    reset = 1'b1;
    model_last = N - 1;
    model_to = 1'b0;
    run_txn(3'b011, 0, 1, 32'h0BAD_F00D, ack_id, rsp_id, rsp_d, n_ack, n_rsp, pd_seen,
            pend_ok, same_cyc, idle_ok, quiet_ok);
    model_last = rr_pick(N - 1, 3'b011);
    checks++;
    if (ack_id !== model_last || rsp_id !== model_last || rsp_d !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL reset_mid_next: ack=%0d rsp=%0d data=%h required %0d/%0d/0badf00d",
               ack_id, rsp_id, rsp_d, model_last, model_last);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) pd_arr[i] = '0;
    test_reset();
    test_single_read();
    test_posted_write();
    test_contention();
    test_random();
    test_spurious_rvalid();
    test_timeout();
    test_reset_mid();
    @(negedge clk);
    i_req_valid = '0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
